// File: rtl/ddr3_pkg.sv
// ddr3_pkg: AXI4 constants and FSM state type shared by the DDR3 burst writer.
package ddr3_pkg;
    localparam logic [2:0] SIZE_32B = 3'b101;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] CACHE_BUF = 4'b0011;
    localparam int BYTES_PER_BEAT = 32;
    localparam int BOUNDARY_4K = 4096;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, FIN} wr_state_t;
endpackage

// File: rtl/ddr3_burst_len_calc.sv
// ddr3_burst_len_calc: beats in the next burst, limited by remaining words, MAX_BURST and the 4 KB boundary.
module ddr3_burst_len_calc
    import ddr3_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [15:0] remaining,
    input  logic [11:0] addr_lo,
    output logic [8:0]  beats
);
    logic [12:0] room;
    logic [8:0]  capped;
    always_comb begin
        room   = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> 5;
        capped = (remaining < 16'(MAX_BURST)) ? remaining[8:0] : 9'(MAX_BURST);
        beats  = ({4'd0, capped} < room) ? capped : room[8:0];
    end
endmodule

// File: rtl/ddr3_burst_writer.sv
// ddr3_burst_writer: splits a write command into 4 KB-safe AXI4 INCR bursts fed straight from a data stream.
module ddr3_burst_writer
    import ddr3_pkg::*;
#(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 16
) (
    input  logic                ui_clk,
    input  logic                ui_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [15:0]         cmd_words,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic [3:0]          m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awlock,
    output logic [3:0]          m_axi_awcache,
    output logic [2:0]          m_axi_awprot,
    output logic [3:0]          m_axi_awqos,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic                busy,
    output logic                done,
    output logic                err
);
    wr_state_t         state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [7:0]        beat;
    logic [8:0]        beats;
    logic [7:0]        last_idx;
    logic              w_hs;
    ddr3_burst_len_calc #(.MAX_BURST(MAX_BURST)) u_len (
        .remaining(remaining),
        .addr_lo  (addr[11:0]),
        .beats    (beats)
    );
    assign last_idx      = 8'(beats - 9'd1);
    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = last_idx;
    assign m_axi_awsize  = SIZE_32B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_BUF;
    assign m_axi_awprot  = '0;
    assign m_axi_awqos   = '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_wdata   = in_data;
    // The stream is wired straight through to W so a beat costs no extra cycle.
    assign cmd_ready     = (state == IDLE) && !ui_rst;
    assign m_axi_awvalid = (state == ADDR);
    assign m_axi_wvalid  = (state == DATA) && in_valid;
    assign in_ready      = (state == DATA) && m_axi_wready;
    assign m_axi_wlast   = (state == DATA) && (beat == last_idx);
    assign m_axi_bready  = (state == RESP);
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid) state_n = (cmd_words == 16'd0) ? FIN : ADDR;
            ADDR:    if (m_axi_awready) state_n = DATA;
            DATA:    if (w_hs && m_axi_wlast) state_n = RESP;
            RESP:    if (m_axi_bvalid) state_n = (remaining == 16'(beats)) ? FIN : ADDR;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beat      <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            if (cmd_valid && cmd_ready) begin
                addr      <= cmd_addr & ~ADDR_W'(BYTES_PER_BEAT - 1);
                remaining <= cmd_words;
                err       <= 1'b0;
            end
            if (w_hs) beat <= m_axi_wlast ? 8'd0 : beat + 8'd1;
            if (m_axi_bvalid && m_axi_bready) begin
                err       <= err | (m_axi_bresp != 2'b00);
                addr      <= addr + ADDR_W'(beats) * ADDR_W'(BYTES_PER_BEAT);
                remaining <= remaining - 16'(beats);
            end
        end
    end
endmodule

// File: tb/tb_ddr3_burst_writer.sv
// tb_ddr3_burst_writer: directed checks of burst splitting, data integrity, errors and reset.
module tb_ddr3_burst_writer;
    logic         ui_clk = 1'b0;
    logic         ui_rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [29:0]  cmd_addr = '0;
    logic [15:0]  cmd_words = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic [3:0]   m_axi_awid;
    logic [29:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awlock;
    logic [3:0]   m_axi_awcache;
    logic [2:0]   m_axi_awprot;
    logic [3:0]   m_axi_awqos;
    logic         m_axi_awvalid;
    logic         m_axi_awready = 1'b0;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready = 1'b0;
    logic [1:0]   m_axi_bresp = 2'b00;
    logic         m_axi_bvalid = 1'b0;
    logic         m_axi_bready;
    logic         busy, done, err;

    ddr3_burst_writer dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 ui_clk = ~ui_clk;

    int checks = 0, errors = 0, cyc = 0;
    bit aw_stall = 0, w_stall = 0, in_stall = 0;
    int src_n = 0, src_idx = 0, src_base = 0;
    bit b_pending = 0;
    int burst_no = 0, bad_burst = -1, beat_no = 0;
    int done_cnt = 0, done_cyc = 0, hs_cyc = 0;
    logic err_at_done = 1'b0;
    logic [29:0] wptr = '0;
    logic [255:0] mem [int];
    logic [29:0] aw_addr_q [$];
    int aw_len_q [$];
    logic aw_err_q [$];
    int last_q [$];

    function automatic logic [255:0] pat(int k);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(k);
        return {4{w, ~w}};
    endfunction

    function automatic int lenq(int i);
        return (i < aw_len_q.size()) ? aw_len_q[i] : -1;
    endfunction

    function automatic logic [31:0] addrq(int i);
        return (i < aw_addr_q.size()) ? {2'b00, aw_addr_q[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic int errq(int i);
        return (i < aw_err_q.size()) ? int'(aw_err_q[i]) : -1;
    endfunction

    function automatic int lastq(int i);
        return (i < last_q.size()) ? last_q[i] : -1;
    endfunction

    function automatic int mem_bad(logic [29:0] a, int n, int base);
        int bad;
        logic [29:0] p;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            p = a + 30'(k * 32);
            if (!mem.exists(int'(p >> 5)) || mem[int'(p >> 5)] !== pat(base + k)) bad++;
        end
        return bad;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave and stream source: drive inputs at negedge, then log the handshakes the next posedge will take.
    always @(negedge ui_clk) begin
        cyc++;
        m_axi_awready = aw_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = w_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid      = (src_idx < src_n) && (!in_stall || $urandom_range(0, 1) == 1);
        in_data       = pat(src_base + src_idx);
        m_axi_bvalid  = b_pending;
        m_axi_bresp   = (burst_no == bad_burst) ? 2'b10 : 2'b00;
        #1;
        if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_q.push_back(m_axi_awaddr);
            aw_len_q.push_back(int'(m_axi_awlen));
            aw_err_q.push_back(err);
            wptr = m_axi_awaddr;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            mem[int'(wptr >> 5)] = m_axi_wdata;
            wptr = wptr + 30'd32;
            beat_no++;
            if (m_axi_wlast) begin
                last_q.push_back(beat_no);
                b_pending = 1;
            end
        end
        if (in_valid && in_ready) src_idx++;
        if (m_axi_bvalid && m_axi_bready) begin
            b_pending = 0;
            burst_no++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            err_at_done = err;
        end
    end

    task automatic clr();
        aw_addr_q.delete(); aw_len_q.delete(); aw_err_q.delete(); last_q.delete(); mem.delete();
        src_n = 0; src_idx = 0; b_pending = 0; burst_no = 0; beat_no = 0; done_cnt = 0; bad_burst = -1;
    endtask

    task automatic start_cmd(input logic [29:0] a, input int words, input int base, input int bad);
        clr();
        src_n = words; src_base = base; bad_burst = bad;
        @(negedge ui_clk); #2;
        cmd_addr = a; cmd_words = 16'(words); cmd_valid = 1'b1; hs_cyc = cyc;
        @(negedge ui_clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge ui_clk); #2;
            n++;
        end
        if (done_cnt == 0) check({tag, "_timeout"}, 1, 0);
        repeat (3) begin
            @(negedge ui_clk); #2;
        end
    endtask

    initial begin
        #1 ui_rst = 1'b1;
        #2 check("rst_outs", {cmd_ready, in_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, err}, 8'h00);
        #20 ui_rst = 1'b0;
        @(negedge ui_clk); #2;
        check("rst_cmd_ready", {cmd_ready, busy}, 2'b10);

        start_cmd(30'h0, 40, 0, -1);
        wait_done("t40");
        check("t40_aw_cnt", aw_len_q.size(), 3);
        check("t40_lens", {8'(lenq(0)), 8'(lenq(1)), 8'(lenq(2))}, {8'd15, 8'd15, 8'd7});
        check("t40_addrs", {addrq(0), addrq(1)}, {32'h0, 32'h200});
        check("t40_addr2", addrq(2), 32'h400);
        check("t40_done", done_cnt, 1);
        check("t40_err", err, 0);
        check("t40_mem", mem_bad(30'h0, 40, 0), 0);
        check("t40_wlast", {8'(lastq(0)), 8'(lastq(1)), 8'(lastq(2))}, {8'd16, 8'd32, 8'd40});

        start_cmd(30'hFDF, 4, 100, -1);
        wait_done("t4k");
        check("t4k_aw", {8'(lenq(0)), 8'(lenq(1)), addrq(0), addrq(1)}, {8'd1, 8'd1, 32'hFC0, 32'h1000});
        check("t4k_wlast", {8'(last_q.size()), 8'(lastq(0)), 8'(lastq(1))}, {8'd2, 8'd2, 8'd4});
        check("t4k_mem", mem_bad(30'hFC0, 4, 100), 0);

        start_cmd(30'h40, 0, 0, -1);
        wait_done("t0");
        check("t0_no_traffic", {aw_len_q.size(), beat_no}, 64'd0);
        check("t0_done_cycle", done_cyc - hs_cyc, 1);
        check("t0_done_cnt", done_cnt, 1);

        aw_stall = 1; w_stall = 1; in_stall = 1;
        start_cmd(30'h1F00, 100, 500, -1);
        wait_done("t100");
        aw_stall = 0; w_stall = 0; in_stall = 0;
        check("t100_mem", mem_bad(30'h1F00, 100, 500), 0);
        check("t100_beats", {beat_no, src_idx}, {32'd100, 32'd100});
        check("t100_first", {8'(lenq(0)), addrq(1)}, {8'd7, 32'h2000});

        start_cmd(30'h3FFF_FFE0, 2, 700, -1);
        wait_done("twrap");
        check("twrap_aw", {8'(aw_len_q.size()), 8'(lenq(0)), addrq(1)}, {8'd2, 8'd0, 32'h0});
        check("twrap_mem", mem_bad(30'h3FFF_FFE0, 2, 700), 0);

        start_cmd(30'h0, 40, 0, 1);
        wait_done("tbr");
        check("tbr_err_seq", {8'(errq(0)), 8'(errq(1)), 8'(errq(2))}, {8'd0, 8'd0, 8'd1});
        check("tbr_err_done", {err_at_done, err}, 2'b11);
        start_cmd(30'h80, 1, 40, -1);
        check("tbr_err_clr", err, 0);
        wait_done("tclr");
        check("tclr_done", {done_cnt, 31'd0, err_at_done}, {32'd1, 32'd0});

        start_cmd(30'h0, 40, 0, -1);
        begin
            int n;
            n = 0;
            while (beat_no < 5 && n < 500) begin
                @(negedge ui_clk); #2;
                n++;
            end
        end
        check("trst_reached_beat5", beat_no, 5);
        ui_rst = 1'b1;
        #1 check("trst_async", {cmd_ready, in_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, done, err}, 8'h00);
        #3 ui_rst = 1'b0;
        clr();
        @(negedge ui_clk); #2;
        check("trst_idle", {cmd_ready, busy}, 2'b10);
        start_cmd(30'h100, 8, 900, -1);
        wait_done("trst2");
        check("trst2_aw", {8'(aw_len_q.size()), 8'(lenq(0)), addrq(0)}, {8'd1, 8'd7, 32'h100});
        check("trst2_mem", {mem_bad(30'h100, 8, 900), done_cnt}, {32'd0, 32'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
